// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: operand width, Oper encodings,
// and the command layout {sign,invB,invA,Cin,Oper,InB,InA}.
package alu_share_arb_pkg;

    localparam int ALU_W = 16;
    localparam int CMD_W = 8 + 2 * ALU_W;

    typedef logic [3:0] oper_t;

    localparam oper_t OP_ROL = 4'b0000;
    localparam oper_t OP_SLL = 4'b0001;
    localparam oper_t OP_ROR = 4'b0010;
    localparam oper_t OP_SRL = 4'b0011;
    localparam oper_t OP_ADD = 4'b0100;
    localparam oper_t OP_AND = 4'b0101;
    localparam oper_t OP_OR  = 4'b0110;
    localparam oper_t OP_XOR = 4'b0111;
    localparam oper_t OP_SEQ = 4'b1000;
    localparam oper_t OP_SLT = 4'b1001;
    localparam oper_t OP_SLE = 4'b1010;
    localparam oper_t OP_BTR = 4'b1011;
    localparam oper_t OP_SCO = 4'b1100;

    typedef struct packed {
        logic             sign;
        logic             inv_b;
        logic             inv_a;
        logic             cin;
        oper_t            oper;
        logic [ALU_W-1:0] in_b;
        logic [ALU_W-1:0] in_a;
    } cmd_t;

    function automatic logic is_reserved(input oper_t op);
        return op > OP_SCO;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester's command/response channel pair; the arbiter takes the slave side.
interface alu_share_arb_if;
    import alu_share_arb_pkg::*;

    logic             req_valid;
    logic             req_ready;
    cmd_t             req_cmd;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ALU_W-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_cmd, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_cmd, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_share_arb_alu.sv
// Combinational 16-bit ALU. Operand inversion happens before every op; sign selects
// signed compares for SLT/SLE. Shift/rotate amount is B[3:0].
module alu
    import alu_share_arb_pkg::*;
(
    input  logic [ALU_W-1:0] in_a,
    input  logic [ALU_W-1:0] in_b,
    input  logic             cin,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             sign,
    input  oper_t            oper,
    output logic [ALU_W-1:0] out
);

    logic [ALU_W-1:0]   a, b;
    logic [ALU_W:0]     sum;
    logic [2*ALU_W-1:0] rol_w, ror_w;
    logic [3:0]         sh;
    logic               eq, lt;

    assign a     = inv_a ? ~in_a : in_a;
    assign b     = inv_b ? ~in_b : in_b;
    assign sum   = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
    assign sh    = b[3:0];
    // Rotates come from a doubled word so no wrap logic is needed.
    assign rol_w = {a, a} << sh;
    assign ror_w = {a, a} >> sh;
    assign eq    = (a == b);
    assign lt    = sign ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        out = '0;
        case (oper)
            OP_ROL: out = rol_w[2*ALU_W-1:ALU_W];
            OP_SLL: out = a << sh;
            OP_ROR: out = ror_w[ALU_W-1:0];
            OP_SRL: out = a >> sh;
            OP_ADD: out = sum[ALU_W-1:0];
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_SEQ: out = {{(ALU_W-1){1'b0}}, eq};
            OP_SLT: out = {{(ALU_W-1){1'b0}}, lt};
            OP_SLE: out = {{(ALU_W-1){1'b0}}, lt | eq};
            OP_BTR: for (int k = 0; k < ALU_W; k++) out[k] = a[ALU_W-1-k];
            OP_SCO: out = {{(ALU_W-1){1'b0}}, sum[ALU_W]};
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin arbiter. Priority flips to the loser only on an actual acceptance.
module rr_arb2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       accept,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic prio_q;

    assign grant[0] = elig[0] & (~elig[1] | ~prio_q);
    assign grant[1] = elig[1] & (~elig[0] |  prio_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prio_q <= RR_INIT;
        else if (flush)  prio_q <= RR_INIT;
        else if (accept) prio_q <= grant[0];
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two valid/ready requesters: one-entry issue reg feeding the
// ALU, then a one-entry response buffer per port. Accept -> response valid is one cycle.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int OPERAND_WIDTH = 16,
    parameter bit RR_INIT       = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    alu_share_arb_if.slave port0,
    alu_share_arb_if.slave port1
);

    logic [1:0]                    req_valid, rsp_ready, rsp_valid, rsp_err;
    logic [1:0]                    elig, grant, ready;
    cmd_t [1:0]                    req_cmd;
    logic [1:0][OPERAND_WIDTH-1:0] rsp_data;
    logic                          accept;

    logic                          s1_v, s1_id;
    cmd_t                          s1_cmd;
    logic [OPERAND_WIDTH-1:0]      alu_out;
    logic                          s1_rsv;

    assign req_valid = {port1.req_valid, port0.req_valid};
    assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};
    assign req_cmd   = {port1.req_cmd,   port0.req_cmd};

    assign port0.req_ready = ready[0];
    assign port0.rsp_valid = rsp_valid[0];
    assign port0.rsp_data  = rsp_data[0];
    assign port0.rsp_err   = rsp_err[0];
    assign port1.req_ready = ready[1];
    assign port1.rsp_valid = rsp_valid[1];
    assign port1.rsp_data  = rsp_data[1];
    assign port1.rsp_err   = rsp_err[1];

    assign accept = |ready;
    assign s1_rsv = is_reserved(s1_cmd.oper);

    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .accept (accept),
        .elig   (elig),
        .grant  (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_id  <= 1'b0;
            s1_cmd <= '0;
        end else if (flush) begin
            s1_v   <= 1'b0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_id  <= grant[1];
                s1_cmd <= grant[1] ? req_cmd[1] : req_cmd[0];
            end
        end
    end

    alu u_alu (
        .in_a  (s1_cmd.in_a),
        .in_b  (s1_cmd.in_b),
        .cin   (s1_cmd.cin),
        .inv_a (s1_cmd.inv_a),
        .inv_b (s1_cmd.inv_b),
        .sign  (s1_cmd.sign),
        .oper  (s1_cmd.oper),
        .out   (alu_out)
    );

    for (genvar i = 0; i < 2; i++) begin : g_port
        logic                     fill;
        logic                     v_q, e_q;
        logic [OPERAND_WIDTH-1:0] d_q;

        // A port may not issue while it has an op in the issue reg, and only into a
        // response buffer that is empty or draining this edge.
        assign elig[i]  = req_valid[i] & ~(s1_v & (s1_id == 1'(i))) &
                          (~rsp_valid[i] | rsp_ready[i]);
        assign ready[i] = grant[i] & ~flush & rst_n;
        assign fill     = s1_v & (s1_id == 1'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
                e_q <= 1'b0;
            end else if (flush) begin
                v_q <= 1'b0;
            end else if (fill) begin
                v_q <= 1'b1;
                d_q <= s1_rsv ? '0 : alu_out;
                e_q <= s1_rsv;
            end else if (rsp_ready[i]) begin
                v_q <= 1'b0;
            end
        end

        assign rsp_valid[i] = v_q;
        assign rsp_data[i]  = d_q;
        assign rsp_err[i]   = e_q;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: single op, alternation, backpressure, reserved op,
// flush and async reset, each with hand-computed expectations.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    alu_share_arb_if p0();
    alu_share_arb_if p1();

    alu_share_arb #(.OPERAND_WIDTH(16), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .port0 (p0),
        .port1 (p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cmd_t mk(input oper_t op, input logic [15:0] a, input logic [15:0] b);
        cmd_t c;
        c = '0;
        c.oper = op;
        c.in_a = a;
        c.in_b = b;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 units after the rising edge; checks happen 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        p0.req_valid = 1'b0; p0.req_cmd = '0; p0.rsp_ready = 1'b1;
        p1.req_valid = 1'b0; p1.req_cmd = '0; p1.rsp_ready = 1'b1;
        p0.req_valid = 1'b1;
        #1;
        chk("rst_ready0", 40'(p0.req_ready), 40'd0);
        chk("rst_rsp0",   40'({p0.rsp_valid, p0.rsp_err, p0.rsp_data}), 40'd0);
        chk("rst_rsp1",   40'({p1.rsp_valid, p1.rsp_err, p1.rsp_data}), 40'd0);
        p0.req_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // single ADD on port 0
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_ADD, 16'h0003, 16'h0004);
        #1 chk("t1_ready0", 40'(p0.req_ready), 40'd1);
        cyc();
        p0.req_valid = 1'b0;
        #1 chk("t1_rsp_not_yet", 40'(p0.rsp_valid), 40'd0);
        cyc();
        #1 chk("t1_rsp", 40'({p0.rsp_valid, p0.rsp_err, p0.rsp_data}), 40'({1'b1, 1'b0, 16'h0007}));
        cyc();
        #1 chk("t1_drained", 40'(p0.rsp_valid), 40'd0);

        // flush restores priority to port 0, then alternate grants
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_AND, 16'hF0F0, 16'h0FF0);
        p1.req_valid = 1'b1; p1.req_cmd = mk(OP_SEQ, 16'h0005, 16'h0005);
        #1 chk("t2_g0", 40'({p1.req_ready, p0.req_ready}), 40'b01);
        cyc();
        #1 chk("t2_g1", 40'({p1.req_ready, p0.req_ready}), 40'b10);
        cyc();
        #1 chk("t2_g2", 40'({p1.req_ready, p0.req_ready}), 40'b01);
        chk("t2_and", 40'({p0.rsp_valid, p0.rsp_data}), 40'({1'b1, 16'h00F0}));
        cyc();
        #1 chk("t2_g3", 40'({p1.req_ready, p0.req_ready}), 40'b10);
        chk("t2_seq", 40'({p1.rsp_valid, p1.rsp_data}), 40'({1'b1, 16'h0001}));
        p0.req_valid = 1'b0; p1.req_valid = 1'b0;
        cyc(); cyc();

        // backpressure on port 0
        p0.rsp_ready = 1'b0;
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_ADD, 16'h0001, 16'h0001);
        #1 chk("t3_ready0", 40'(p0.req_ready), 40'd1);
        cyc();
        p0.req_cmd = mk(OP_ADD, 16'h0002, 16'h0002);
        p1.req_valid = 1'b1; p1.req_cmd = mk(OP_XOR, 16'hFFFF, 16'h00FF);
        #1 chk("t3_inflight", 40'({p1.req_ready, p0.req_ready}), 40'b10);
        cyc();
        #1 chk("t3_full", 40'({p0.rsp_valid, p0.rsp_data}), 40'({1'b1, 16'h0002}));
        chk("t3_blocked", 40'({p1.req_ready, p0.req_ready}), 40'b00);
        cyc();
        #1 chk("t3_p1_grant", 40'({p1.req_ready, p0.req_ready}), 40'b10);
        chk("t3_xor", 40'({p1.rsp_valid, p1.rsp_data}), 40'({1'b1, 16'hFF00}));
        p1.req_valid = 1'b0;
        cyc();
        #1 chk("t3_hold", 40'({p0.rsp_valid, p0.rsp_data, p0.req_ready}), 40'({1'b1, 16'h0002, 1'b0}));
        p0.rsp_ready = 1'b1;
        #1 chk("t3_same_cycle", 40'(p0.req_ready), 40'd1);
        cyc();
        p0.req_valid = 1'b0;
        #1 chk("t3_drained", 40'(p0.rsp_valid), 40'd0);
        cyc();
        #1 chk("t3_second", 40'({p0.rsp_valid, p0.rsp_data}), 40'({1'b1, 16'h0004}));
        cyc();

        // reserved Oper on port 1
        p1.req_valid = 1'b1; p1.req_cmd = mk(4'b1110, 16'h1234, 16'h5678);
        #1 chk("t4_ready1", 40'(p1.req_ready), 40'd1);
        cyc();
        p1.req_valid = 1'b0;
        cyc();
        #1 chk("t4_rsv", 40'({p1.rsp_valid, p1.rsp_err, p1.rsp_data}), 40'({1'b1, 1'b1, 16'h0000}));
        chk("t4_noX", 40'($isunknown({p1.rsp_valid, p1.rsp_err, p1.rsp_data})), 40'd0);
        cyc();

        // flush with rsp0 full and a port-1 op in flight
        p0.rsp_ready = 1'b0;
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_ADD, 16'h0005, 16'h0005);
        cyc();
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b1; p1.req_cmd = mk(OP_ADD, 16'h0001, 16'h0002);
        cyc();
        flush = 1'b1;
        p0.req_valid = 1'b1; p1.req_valid = 1'b1;
        #1 chk("t5_pre", 40'({p0.rsp_valid, p0.rsp_data}), 40'({1'b1, 16'h000A}));
        chk("t5_no_accept", 40'({p1.req_ready, p0.req_ready}), 40'b00);
        cyc();
        flush = 1'b0;
        p0.req_valid = 1'b0; p1.req_valid = 1'b0;
        #1 chk("t5_cleared", 40'({p1.rsp_valid, p0.rsp_valid}), 40'b00);
        cyc();
        #1 chk("t5_no_late", 40'({p1.rsp_valid, p0.rsp_valid}), 40'b00);
        p0.rsp_ready = 1'b1;
        // give port 1 priority, then check flush hands it back to port 0
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_ADD, 16'h0000, 16'h0000);
        cyc();
        p0.req_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        p0.req_valid = 1'b1; p1.req_valid = 1'b1;
        #1 chk("t5_prio", 40'({p1.req_ready, p0.req_ready}), 40'b01);
        p0.req_valid = 1'b0; p1.req_valid = 1'b0;
        cyc();

        // async reset between edges
        p0.rsp_ready = 1'b0;
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_ADD, 16'h0009, 16'h0009);
        cyc();
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b1; p1.req_cmd = mk(OP_ADD, 16'h0001, 16'h0001);
        cyc();
        #1 chk("t6_pre", 40'({p0.rsp_valid, p0.rsp_data}), 40'({1'b1, 16'h0012}));
        rst_n = 1'b0;
        #1 chk("t6_async", 40'({p0.rsp_valid, p0.rsp_err, p0.rsp_data, p1.req_ready}), 40'd0);
        p1.req_valid = 1'b0;
        p0.rsp_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        #1 chk("t6_no_late", 40'({p1.rsp_valid, p0.rsp_valid}), 40'b00);
        p0.req_valid = 1'b1; p0.req_cmd = mk(OP_ADD, 16'h0003, 16'h0004);
        #1 chk("t6_ready0", 40'(p0.req_ready), 40'd1);
        cyc();
        p0.req_valid = 1'b0;
        #1 chk("t6_not_yet", 40'(p0.rsp_valid), 40'd0);
        cyc();
        #1 chk("t6_rsp", 40'({p0.rsp_valid, p0.rsp_err, p0.rsp_data}), 40'({1'b1, 1'b0, 16'h0007}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
